// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: default geometry, level margins and overflow counter width for rx_fifo.
package rx_fifo_pkg;
  localparam int DATA_WIDTH_D = 8;
  localparam int ADDR_WIDTH_D = 10;
  localparam int AFULL_MARGIN_D = 4;
  localparam int AEMPTY_MARGIN_D = 4;
  localparam int OVF_CNT_W = 16;
endpackage

// File: rtl/rx_fifo_if.sv
// rx_fifo_if: push/pop handshake, level flags and overflow status of rx_fifo.
interface rx_fifo_if import rx_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D
);
  logic                  i_push;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_pop;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_rvalid;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_afull;
  logic                  o_aempty;
  logic [ADDR_WIDTH:0]   o_count;
  logic                  i_ovf_clr;
  logic                  o_ovf;
  logic [OVF_CNT_W-1:0]  o_ovf_cnt;
  modport master (
    output i_push, i_wdata, i_pop, i_ovf_clr,
    input  o_rdata, o_rvalid, o_full, o_empty, o_afull, o_aempty, o_count, o_ovf, o_ovf_cnt
  );
  modport slave (
    input  i_push, i_wdata, i_pop, i_ovf_clr,
    output o_rdata, o_rvalid, o_full, o_empty, o_afull, o_aempty, o_count, o_ovf, o_ovf_cnt
  );
endinterface

// File: rtl/rx_fifo_ram.sv
// rx_fifo_ram: simple dual-port RAM, single clock, registered read; the array is never reset.
module rx_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge i_clk)
    if (i_wen) mem[i_waddr] <= i_wdata;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_rdata <= '0;
    else if (i_ren) o_rdata <= mem[i_raddr];
endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: receive FIFO with registered level flags and sticky overflow; RX_FIFO_OVF_CNT_EN adds a dropped-push counter.
module rx_fifo import rx_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int AFULL_MARGIN = AFULL_MARGIN_D,
  parameter int AEMPTY_MARGIN = AEMPTY_MARGIN_D
) (
  input logic i_clk,
  input logic i_rst_n,
  rx_fifo_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = CW'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = CW'(2**ADDR_WIDTH - AFULL_MARGIN);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = CW'(AEMPTY_MARGIN);
  logic [ADDR_WIDTH:0] wptr, rptr, count, count_nxt;
  logic full, empty, push_ok, pop_ok, drop;
  logic [DATA_WIDTH-1:0] rdata;
  // acceptance uses pre-edge pointer state, so a push at full drops even alongside a pop
  assign empty = wptr == rptr;
  assign full = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign push_ok = bus.i_push & ~full;
  assign pop_ok = bus.i_pop & ~empty;
  assign drop = bus.i_push & full;
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign bus.o_count = count;
  assign bus.o_rdata = rdata;
  rx_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_waddr(wptr[ADDR_WIDTH-1:0]),
    .i_wen(push_ok),
    .i_wdata(bus.i_wdata),
    .i_raddr(rptr[ADDR_WIDTH-1:0]),
    .i_ren(pop_ok),
    .o_rdata(rdata)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      bus.o_full <= 1'b0;
      bus.o_empty <= 1'b1;
      bus.o_afull <= 1'b0;
      bus.o_aempty <= 1'b1;
      bus.o_rvalid <= 1'b0;
      bus.o_ovf <= 1'b0;
    end else begin
      wptr <= wptr + CW'(push_ok);
      rptr <= rptr + CW'(pop_ok);
      count <= count_nxt;
      bus.o_full <= count_nxt == DEPTH_L;
      bus.o_empty <= count_nxt == '0;
      bus.o_afull <= count_nxt >= AFULL_LVL;
      bus.o_aempty <= count_nxt <= AEMPTY_LVL;
      bus.o_rvalid <= pop_ok;
      bus.o_ovf <= drop | (bus.o_ovf & ~bus.i_ovf_clr);
    end
`ifdef RX_FIFO_OVF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) bus.o_ovf_cnt <= '0;
    else if (bus.i_ovf_clr) bus.o_ovf_cnt <= OVF_CNT_W'(drop);
    else if (drop && !(&bus.o_ovf_cnt)) bus.o_ovf_cnt <= bus.o_ovf_cnt + 1'b1;
`else
  assign bus.o_ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: randomized scenarios for rx_fifo checked against a queue-based reference model.
module tb_rx_fifo;
  import rx_fifo_pkg::*;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = AW + 1;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_MARGIN(4), .AEMPTY_MARGIN(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata;
  bit m_rvalid, m_ovf;
  int m_ovf_cnt;
  int n_checks, n_fail;

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_rvalid = 0;
    m_ovf = 0;
    m_ovf_cnt = 0;
  endtask

  task automatic step(input bit push, input logic [DW-1:0] d, input bit pop, input bit clr);
    bit pop_ok, push_ok, drop;
    bus.i_push = push;
    bus.i_wdata = d;
    bus.i_pop = pop;
    bus.i_ovf_clr = clr;
    @(posedge clk);
    pop_ok = pop && q.size() > 0;
    push_ok = push && q.size() < DEPTH;
    drop = push && q.size() == DEPTH;
    m_rvalid = pop_ok;
    if (pop_ok) m_rdata = q.pop_front();
    if (push_ok) q.push_back(d);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
`ifdef RX_FIFO_OVF_CNT_EN
    if (clr) m_ovf_cnt = drop ? 1 : 0;
    else if (drop && m_ovf_cnt < 65535) m_ovf_cnt++;
`endif
    #1;
    bus.i_push = 0;
    bus.i_pop = 0;
    bus.i_ovf_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: empty=%b aempty=%b want 1 1", bus.o_empty, bus.o_aempty); end
    n_checks++; if (bus.o_full !== 1'b0 || bus.o_afull !== 1'b0 || bus.o_rvalid !== 1'b0 || bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags: full=%b afull=%b rvalid=%b ovf=%b want 0", bus.o_full, bus.o_afull, bus.o_rvalid, bus.o_ovf); end
    n_checks++; if (bus.o_count !== '0 || bus.o_rdata !== '0 || bus.o_ovf_cnt !== '0) begin n_fail++; $display("FAIL reset_values: count=%0d rdata=%h ovf_cnt=%0d want 0", bus.o_count, bus.o_rdata, bus.o_ovf_cnt); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] words[3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(1, words[i], 0, 0);
    n_checks++; if (bus.o_count !== CW'(3) || bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL basic_count: count=%0d empty=%b want 3 0", bus.o_count, bus.o_empty); end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 0);
      n_checks++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== m_rdata) begin n_fail++; $display("FAIL basic_pop%0d: rvalid=%b rdata=%h want 1 %h", i, bus.o_rvalid, bus.o_rdata, m_rdata); end
    end
    step(0, '0, 0, 0);
    n_checks++; if (bus.o_rvalid !== 1'b0 || bus.o_rdata !== 8'h33) begin n_fail++; $display("FAIL basic_hold: rvalid=%b rdata=%h want 0 33", bus.o_rvalid, bus.o_rdata); end
    n_checks++; if (bus.o_count !== '0 || bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL basic_end: count=%0d empty=%b want 0 1", bus.o_count, bus.o_empty); end
  endtask

  task automatic test_fill();
    while (q.size() < DEPTH) begin
      step(1, DW'($urandom), 0, 0);
      n_checks++;
      if (bus.o_count !== CW'(q.size()) || bus.o_afull !== (q.size() >= DEPTH - 4) ||
          bus.o_full !== (q.size() == DEPTH) || bus.o_aempty !== (q.size() <= 4) || bus.o_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_level: count=%0d full=%b afull=%b aempty=%b want count %0d", bus.o_count, bus.o_full, bus.o_afull, bus.o_aempty, q.size());
      end
    end
    step(1, 8'hAA, 0, 0);
    n_checks++; if (bus.o_ovf !== 1'b1 || bus.o_ovf_cnt !== 16'(m_ovf_cnt)) begin n_fail++; $display("FAIL fill_drop: ovf=%b ovf_cnt=%0d want 1 %0d", bus.o_ovf, bus.o_ovf_cnt, m_ovf_cnt); end
    n_checks++; if (bus.o_count !== CW'(DEPTH) || bus.o_full !== 1'b1) begin n_fail++; $display("FAIL fill_hold: count=%0d full=%b want %0d 1", bus.o_count, bus.o_full, DEPTH); end
  endtask

  task automatic test_full_push_pop();
    step(1, 8'hBB, 1, 0);
    n_checks++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== m_rdata) begin n_fail++; $display("FAIL fullpp_data: rvalid=%b rdata=%h want 1 %h", bus.o_rvalid, bus.o_rdata, m_rdata); end
    n_checks++; if (bus.o_count !== CW'(DEPTH - 1) || bus.o_full !== 1'b0 || bus.o_ovf_cnt !== 16'(m_ovf_cnt)) begin n_fail++; $display("FAIL fullpp_count: count=%0d full=%b ovf_cnt=%0d want %0d 0 %0d", bus.o_count, bus.o_full, bus.o_ovf_cnt, DEPTH - 1, m_ovf_cnt); end
    step(0, '0, 0, 1);
    n_checks++; if (bus.o_ovf !== 1'b0 || bus.o_ovf_cnt !== '0) begin n_fail++; $display("FAIL ovf_clear: ovf=%b ovf_cnt=%0d want 0 0", bus.o_ovf, bus.o_ovf_cnt); end
    step(1, DW'($urandom), 0, 0);
    step(1, DW'($urandom), 0, 1);
    n_checks++; if (bus.o_ovf !== 1'b1 || bus.o_ovf_cnt !== 16'(m_ovf_cnt)) begin n_fail++; $display("FAIL ovf_set_wins: ovf=%b ovf_cnt=%0d want 1 %0d", bus.o_ovf, bus.o_ovf_cnt, m_ovf_cnt); end
    step(0, '0, 0, 1);
    while (q.size() > 0) begin
      step(0, '0, 1, 0);
      n_checks++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== m_rdata || bus.o_count !== CW'(q.size())) begin n_fail++; $display("FAIL drain: rvalid=%b rdata=%h count=%0d want 1 %h %0d", bus.o_rvalid, bus.o_rdata, bus.o_count, m_rdata, q.size()); end
    end
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: empty=%b aempty=%b want 1 1", bus.o_empty, bus.o_aempty); end
  endtask

  task automatic test_pop_empty_push();
    step(1, 8'h5A, 1, 0);
    n_checks++; if (bus.o_rvalid !== 1'b0 || bus.o_count !== CW'(1) || bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL empty_pp: rvalid=%b count=%0d empty=%b want 0 1 0", bus.o_rvalid, bus.o_count, bus.o_empty); end
    step(0, '0, 1, 0);
    n_checks++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 8'h5A) begin n_fail++; $display("FAIL empty_pp_pop: rvalid=%b rdata=%h want 1 5a", bus.o_rvalid, bus.o_rdata); end
  endtask

  task automatic test_back_to_back();
    while (q.size() < DEPTH / 2) step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(1, DW'($urandom), 1, 0);
      n_checks++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== m_rdata || bus.o_count !== CW'(DEPTH / 2)) begin n_fail++; $display("FAIL b2b_%0d: rvalid=%b rdata=%h count=%0d want 1 %h %0d", i, bus.o_rvalid, bus.o_rdata, bus.o_count, m_rdata, DEPTH / 2); end
    end
    while (q.size() > 0) step(0, '0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
      n_checks++;
      if (bus.o_count !== CW'(q.size()) || bus.o_empty !== (q.size() == 0) || bus.o_aempty !== (q.size() <= 4) ||
          bus.o_rvalid !== m_rvalid || (m_rvalid && bus.o_rdata !== m_rdata) || bus.o_ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL random_%0d: count=%0d rvalid=%b rdata=%h ovf=%b want %0d %b %h %b", i, bus.o_count, bus.o_rvalid, bus.o_rdata, bus.o_ovf, q.size(), m_rvalid, m_rdata, m_ovf);
      end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) step(0, '0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, DW'($urandom), 0, 0);
    n_checks++; if (bus.o_count !== CW'(7)) begin n_fail++; $display("FAIL areset_pre: count=%0d want 7", bus.o_count); end
    rst_n = 0;
    model_reset();
    #1;
    n_checks++; if (bus.o_count !== '0 || bus.o_empty !== 1'b1 || bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL areset_now: count=%0d empty=%b aempty=%b want 0 1 1", bus.o_count, bus.o_empty, bus.o_aempty); end
    @(posedge clk);
    #1 rst_n = 1;
    step(1, 8'h77, 0, 0);
    step(1, DW'($urandom), 0, 0);
    step(0, '0, 1, 0);
    n_checks++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 8'h77) begin n_fail++; $display("FAIL areset_first: rvalid=%b rdata=%h want 1 77", bus.o_rvalid, bus.o_rdata); end
  endtask

  initial begin
    bus.i_push = 0;
    bus.i_wdata = '0;
    bus.i_pop = 0;
    bus.i_ovf_clr = 0;
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_fill();
    test_full_push_pop();
    test_pop_empty_push();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
